// File: rtl/circular_dma_mc.sv
`default_nettype none
// ============================================================================
// Module   : circular_dma_mc
// Purpose  : Merges C_NUM_CHANNELS AXI-Stream sources onto one AXI4 write
//            master, one burst at a time. Each channel fills its own circular
//            buffer and stalls rather than overwrite data that software has
//            not consumed yet (rd_ptr).
// Ports    : clk/rst            - clock, synchronous active-high reset
//            enable             - per-channel enable
//            buf_base/buf_size  - per-channel buffer placement (bytes)
//            rd_ptr / wr_ptr    - software read offset / committed write offset
//            fifo_occupancy     - beats waiting in each capture FIFO
//            s_axis_*           - per-channel input streams (flattened)
//            irq / err          - burst-done pulse / sticky bad-bresp flag
//            m_axi_aw*/w*/b*    - AXI4 write master
// Revision : 1.0 - initial release
// ============================================================================
module circular_dma_mc #(
  parameter int         C_NUM_CHANNELS     = 2,
  parameter int         C_ADDR_WIDTH       = 32,
  parameter int         C_AXIS_WIDTH       = 64,
  parameter int         C_MAX_BURST        = 16,
  parameter int         C_AXIS_OCCUP_WIDTH = 16,
  parameter logic [2:0] C_VALUE_AWPROT     = 3'd0,
  parameter logic [3:0] C_VALUE_AWCACHE    = 4'b1111,
  parameter logic [3:0] C_VALUE_AWUSER     = 4'b1111
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [C_NUM_CHANNELS-1:0]                    enable,
  input  logic [C_NUM_CHANNELS*C_ADDR_WIDTH-1:0]       buf_base,
  input  logic [C_NUM_CHANNELS*C_ADDR_WIDTH-1:0]       buf_size,
  input  logic [C_NUM_CHANNELS*C_ADDR_WIDTH-1:0]       rd_ptr,
  output logic [C_NUM_CHANNELS*C_ADDR_WIDTH-1:0]       wr_ptr,
  input  logic [C_NUM_CHANNELS*C_AXIS_OCCUP_WIDTH-1:0] fifo_occupancy,
  input  logic [C_NUM_CHANNELS*C_AXIS_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                    s_axis_tvalid,
  output logic [C_NUM_CHANNELS-1:0]                    s_axis_tready,
  output logic [C_NUM_CHANNELS-1:0]                    irq,
  output logic [C_NUM_CHANNELS-1:0]                    err,
  output logic [C_ADDR_WIDTH-1:0]                      m_axi_awaddr,
  output logic [7:0]                                   m_axi_awlen,
  output logic [2:0]                                   m_axi_awsize,
  output logic [1:0]                                   m_axi_awburst,
  output logic [2:0]                                   m_axi_awprot,
  output logic [3:0]                                   m_axi_awcache,
  output logic [3:0]                                   m_axi_awuser,
  output logic                                         m_axi_awvalid,
  input  logic                                         m_axi_awready,
  output logic [C_AXIS_WIDTH-1:0]                      m_axi_wdata,
  output logic [C_AXIS_WIDTH/8-1:0]                    m_axi_wstrb,
  output logic                                         m_axi_wlast,
  output logic                                         m_axi_wvalid,
  input  logic                                         m_axi_wready,
  input  logic [1:0]                                   m_axi_bresp,
  input  logic                                         m_axi_bvalid,
  output logic                                         m_axi_bready
);

  localparam int N     = C_NUM_CHANNELS;
  localparam int AW    = C_ADDR_WIDTH;
  localparam int AWX   = C_ADDR_WIDTH + 1;
  localparam int DW    = C_AXIS_WIDTH;
  localparam int OW    = C_AXIS_OCCUP_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int CH_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (AWX > OW) ? AWX : OW;
  localparam int LEN_W = 9;

  localparam logic [AWX-1:0] BYTES_X = AWX'(BYTES);
  localparam logic [AWX-1:0] MAX_X   = AWX'(C_MAX_BURST);
  localparam logic [AWX-1:0] MASK_X  = AWX'(C_MAX_BURST - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]       r_state;
  logic [CH_W-1:0]  r_sel;
  logic [CH_W-1:0]  r_last;
  logic [N-1:0]     r_elig;
  logic [AW-1:0]    r_awaddr;
  logic [7:0]       r_awlen;
  logic [7:0]       r_beat;
  logic [N-1:0]     r_irq;
  logic [N-1:0]     r_err;
  logic [AW-1:0]    r_wr [N];

  logic [AW-1:0]    w_base [N];
  logic [AW-1:0]    w_size [N];
  logic [LEN_W-1:0] w_len  [N];
  logic [N-1:0]     w_elig;
  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  w_owner;
  logic             w_busy;
  logic             w_wvalid;
  logic [AWX-1:0]   w_sum;
  logic [AWX-1:0]   w_next;

  // Per-channel free space, burst length candidate and eligibility.
  for (genvar i = 0; i < N; i++) begin : g_chan
    logic [AWX-1:0] rd_x, wr_x, size_x, free_bytes, free_beats, room;
    logic [CW-1:0]  occ_c, free_c, room_c, min_fr, len_c;

    assign w_base[i] = buf_base[i*AW +: AW];
    assign w_size[i] = buf_size[i*AW +: AW];
    assign rd_x      = {1'b0, rd_ptr[i*AW +: AW]};
    assign wr_x      = {1'b0, r_wr[i]};
    assign size_x    = {1'b0, w_size[i]};

    // One beat always stays empty, so rd == wr reads as "size - B" free.
    assign free_bytes = (rd_x > wr_x) ? (rd_x - wr_x - BYTES_X)
                                      : (rd_x + size_x - wr_x - BYTES_X);
    assign free_beats = free_bytes >> SHIFT;
    // Beats left before the next C_MAX_BURST-aligned boundary; buffer ends
    // and 4 KB pages both sit on such boundaries.
    assign room       = MAX_X - ((wr_x >> SHIFT) & MASK_X);

    assign occ_c  = CW'(fifo_occupancy[i*OW +: OW]);
    assign free_c = CW'(free_beats);
    assign room_c = CW'(room);
    assign min_fr = (free_c < room_c) ? free_c : room_c;
    assign len_c  = (occ_c < min_fr) ? occ_c : min_fr;
    assign w_len[i] = LEN_W'(len_c);

    assign w_elig[i] = enable[i] && (occ_c != '0) && (free_beats != '0);

    assign wr_ptr[i*AW +: AW] = r_wr[i];
    assign s_axis_tready[i]   = (r_state == S_DATA) && (r_sel == CH_W'(i))
                                && m_axi_wready;
  end

  // Round-robin over the mask captured in IDLE, starting after last grant.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(r_last) + k;
      if (idx >= N) idx = idx - N;
      if (!found && r_elig[idx]) begin
        found   = 1'b1;
        w_grant = CH_W'(idx);
      end
    end
  end

  assign w_busy   = (r_state != S_IDLE);
  assign w_owner  = (r_state == S_ARB) ? w_grant : r_sel;
  assign w_wvalid = (r_state == S_DATA) && s_axis_tvalid[r_sel];

  // Committed pointer after the current burst, wrapped to the buffer start.
  assign w_sum  = {1'b0, r_wr[r_sel]} + ((AWX'(r_awlen) + AWX'(1)) << SHIFT);
  assign w_next = (w_sum >= {1'b0, w_size[r_sel]}) ? (w_sum - {1'b0, w_size[r_sel]})
                                                   : w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_last   <= CH_W'(N - 1);
      r_elig   <= '0;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_beat   <= '0;
      r_irq    <= '0;
      r_err    <= '0;
      for (int i = 0; i < N; i++) r_wr[i] <= '0;
    end else begin
      r_irq <= '0;
      for (int i = 0; i < N; i++) begin
        if (!enable[i] && !(w_busy && (w_owner == CH_W'(i)))) r_wr[i] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_elig  <= w_elig;
            r_state <= S_ARB;
          end
        end
        S_ARB: begin
          r_sel    <= w_grant;
          r_last   <= w_grant;
          r_awaddr <= w_base[w_grant] + r_wr[w_grant];
          r_awlen  <= 8'(w_len[w_grant] - LEN_W'(1));
          r_state  <= S_ADDR;
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            r_beat  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wvalid && m_axi_wready) begin
            if (r_beat == r_awlen) r_state <= S_RESP;
            else                   r_beat  <= r_beat + 8'd1;
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            r_wr[r_sel]  <= w_next[AW-1:0];
            r_irq[r_sel] <= 1'b1;
            if (m_axi_bresp != 2'b00) r_err[r_sel] <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq           = r_irq;
  assign err           = r_err;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SHIFT);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awprot  = C_VALUE_AWPROT;
  assign m_axi_awcache = C_VALUE_AWCACHE;
  assign m_axi_awuser  = C_VALUE_AWUSER;
  assign m_axi_awvalid = (r_state == S_ADDR);
  assign m_axi_wdata   = s_axis_tdata[r_sel*DW +: DW];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (r_state == S_DATA) && (r_beat == r_awlen);
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_bready  = (r_state == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_circular_dma_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_circular_dma_mc
// Purpose  : Self-checking bench for circular_dma_mc (2 channels, 64-bit).
//            A table of phases sets enables, FIFO fills and read pointers;
//            an arithmetic model predicts every burst, and the AXI slave
//            side adds random awready delay, wready and tvalid gaps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circular_dma_mc;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   enable;
  logic [63:0]  buf_base, buf_size, rd_ptr;
  logic [63:0]  wr_ptr;
  logic [31:0]  fifo_occupancy;
  logic [127:0] s_axis_tdata;
  logic [1:0]   s_axis_tvalid, s_axis_tready, irq, err;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize, m_axi_awprot;
  logic [1:0]   m_axi_awburst, m_axi_bresp;
  logic [3:0]   m_axi_awcache, m_axi_awuser;
  logic         m_axi_awvalid, m_axi_awready;
  logic [63:0]  m_axi_wdata;
  logic [7:0]   m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic         m_axi_bvalid, m_axi_bready;

  circular_dma_mc dut (
    .clk(clk), .rst(rst), .enable(enable), .buf_base(buf_base), .buf_size(buf_size),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .fifo_occupancy(fifo_occupancy),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .irq(irq), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot), .m_axi_awcache(m_axi_awcache),
    .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  longint      m_base [2];
  longint      m_size [2];
  longint      m_rd   [2];
  longint      m_wr   [2];
  int          m_last;
  logic [1:0]  m_err;
  logic [1:0]  err_mask;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  en;
    int          push0, push1;
    logic [31:0] rd0, rd1;
    int          exp_nb;
    logic [31:0] exp_wr0, exp_wr1;
    logic [1:0]  err_inj;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void apply_inputs();
    buf_base       = {32'(m_base[1]), 32'(m_base[0])};
    buf_size       = {32'(m_size[1]), 32'(m_size[0])};
    rd_ptr         = {32'(m_rd[1]),   32'(m_rd[0])};
    fifo_occupancy = {16'(q1.size()), 16'(q0.size())};
  endfunction

  // Next burst from the buffer rules: round-robin after the last grant,
  // length = min(occupancy, free beats, beats to next 16-beat boundary).
  function automatic void predict(output bit found, output int ch,
                                  output logic [31:0] addr, output int len);
    longint free, fb, room, occ, l;
    int c;
    found = 0; ch = 0; addr = '0; len = 0;
    for (int k = 1; k <= 2; k++) begin
      c    = (m_last + k) % 2;
      occ  = (c == 0) ? q0.size() : q1.size();
      free = m_rd[c] - m_wr[c] - 8;
      free = ((free % m_size[c]) + m_size[c]) % m_size[c];
      fb   = free / 8;
      room = 16 - ((m_wr[c] / 8) % 16);
      if (!found && enable[c] && occ > 0 && fb > 0) begin
        l = occ;
        if (fb < l)   l = fb;
        if (room < l) l = room;
        found = 1; ch = c; addr = 32'(m_base[c] + m_wr[c]); len = int'(l);
      end
    end
  endfunction

  task automatic apply_phase(input logic [1:0] en, input int p0, input int p1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
    enable = en;
    for (int c = 0; c < 2; c++) if (!en[c]) m_wr[c] = 0;
    for (int i = 0; i < p0; i++) q0.push_back({$urandom, $urandom});
    for (int i = 0; i < p1; i++) q1.push_back({$urandom, $urandom});
    m_rd[0] = longint'(rd0);
    m_rd[1] = longint'(rd1);
    apply_inputs();
  endtask

  task automatic do_burst(input int ch, input logic [31:0] addr, input int len,
                          input logic [1:0] resp);
    int t, d, beat;
    bit hs;
    logic [63:0] front;
    s_axis_tvalid = 2'b11;
    t = 0;
    while (!m_axi_awvalid && t < 100) begin @(negedge clk); t++; end
    if (!m_axi_awvalid) begin
      check("aw_timeout", 64'd0, 64'd1);
      s_axis_tvalid = 2'b00;
      return;
    end
    check("awaddr", m_axi_awaddr, addr);
    check("awlen", m_axi_awlen, 64'(len - 1));
    check("w_before_aw", {m_axi_wvalid, s_axis_tready}, 64'd0);
    d = $urandom_range(0, 5);
    repeat (d) @(negedge clk);
    check("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, addr, 8'(len - 1)});
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    beat = 0; t = 0;
    while (beat < len && t < 2000) begin
      front         = (ch == 0) ? q0[0] : q1[0];
      m_axi_wready  = ($urandom_range(0, 3) != 0);
      s_axis_tvalid = 2'($urandom_range(0, 3));
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tdata[ch*64 +: 64] = front;
      #1;
      check("wvalid", m_axi_wvalid, s_axis_tvalid[ch]);
      check("tready", s_axis_tready, m_axi_wready ? (64'd1 << ch) : 64'd0);
      hs = m_axi_wvalid && m_axi_wready;
      if (hs) begin
        check("wdata", m_axi_wdata, front);
        check("wlast", m_axi_wlast, beat == len - 1);
      end
      @(negedge clk);
      if (hs) begin
        if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        beat++;
        apply_inputs();
      end
      t++;
    end
    if (beat < len) check("w_timeout", 64'(beat), 64'(len));
    m_axi_wready  = 1'b1;
    s_axis_tvalid = 2'b11;
    #1;
    check("w_after_last", {m_axi_wvalid, s_axis_tready}, 64'd0);
    d = $urandom_range(0, 3);
    repeat (d) @(negedge clk);
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    #1;
    check("bready", m_axi_bready, 64'd1);
    @(negedge clk);
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    s_axis_tvalid = 2'b00;
    m_wr[ch] = m_wr[ch] + len * 8;
    if (m_wr[ch] >= m_size[ch]) m_wr[ch] = m_wr[ch] - m_size[ch];
    if (resp != 2'b00) m_err[ch] = 1'b1;
    m_last = ch;
    check("irq", irq, 64'd1 << ch);
    check("wr_ptr", wr_ptr[ch*32 +: 32], 64'(m_wr[ch]));
    check("err", err, m_err);
    @(negedge clk);
    check("irq_pulse_aw_gap", {irq, m_axi_awvalid}, 64'd0);
  endtask

  task automatic run_until_idle(output int nb);
    bit found, seen;
    int ch, len;
    logic [31:0] addr;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      predict(found, ch, addr, len);
      if (!found) break;
      do_burst(ch, addr, len, err_mask[ch] ? 2'b10 : 2'b00);
      nb++;
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_axi_awvalid) seen = 1;
    end
    check("no_aw_when_idle", seen, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, t;
    logic [63:0] front;

    // phase table: en, push0, push1, rd0, rd1, bursts, wr0, wr1, err inject
    vecs[0] = '{2'b01, 40,  0, 32'h000, 32'h0, 3, 32'h140, 32'h000, 2'b00};
    vecs[1] = '{2'b01, 10,  0, 32'h148, 32'h0, 0, 32'h140, 32'h000, 2'b00};
    vecs[2] = '{2'b01,  0,  0, 32'h1C0, 32'h0, 2, 32'h190, 32'h000, 2'b00};
    vecs[3] = '{2'b01, 70,  0, 32'h000, 32'h0, 5, 32'h3C0, 32'h000, 2'b00};
    vecs[4] = '{2'b01, 32,  0, 32'h200, 32'h0, 3, 32'h0C0, 32'h000, 2'b00};
    vecs[5] = '{2'b11, 64, 64, 32'h0C0, 32'h0, 9, 32'h2C0, 32'h200, 2'b00};
    vecs[6] = '{2'b10,  0,  4, 32'h000, 32'h0, 1, 32'h000, 32'h220, 2'b10};
    vecs[7] = '{2'b10,  0,  4, 32'h000, 32'h0, 1, 32'h000, 32'h240, 2'b00};

    m_base[0] = 64'h1000_0000; m_size[0] = 64'h400;
    m_base[1] = 64'h2000_0000; m_size[1] = 64'h800;
    m_rd[0] = 0; m_rd[1] = 0; m_wr[0] = 0; m_wr[1] = 0;
    m_last = 1; m_err = 2'b00; err_mask = 2'b00;
    enable = 2'b00; s_axis_tvalid = 2'b00; s_axis_tdata = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    apply_inputs();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                         s_axis_tready, irq, err}, 64'd0);
    check("reset_aw", {m_axi_awaddr, m_axi_awlen}, 64'd0);
    check("reset_wr_ptr", wr_ptr, 64'd0);
    check("aw_constants", {m_axi_awsize, m_axi_awburst, m_axi_awprot, m_axi_awcache,
                           m_axi_awuser, m_axi_wstrb}, {3'd3, 2'b01, 3'd0, 4'hF, 4'hF, 8'hFF});
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      apply_phase(vecs[v].en, vecs[v].push0, vecs[v].push1, vecs[v].rd0, vecs[v].rd1);
      err_mask = vecs[v].err_inj;
      run_until_idle(nb);
      check("phase_bursts", 64'(nb), 64'(vecs[v].exp_nb));
      check("phase_wr0", wr_ptr[31:0], vecs[v].exp_wr0);
      check("phase_wr1", wr_ptr[63:32], vecs[v].exp_wr1);
    end
    err_mask = 2'b00;
    check("err_sticky", err, 64'h2);

    // Reset in the middle of a burst's data phase.
    apply_phase(2'b01, 16, 0, 32'h0, 32'h0);
    t = 0;
    while (!m_axi_awvalid && t < 50) begin @(negedge clk); t++; end
    check("rst_seq_awaddr", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 32'h1000_0000});
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      front = q0[0];
      s_axis_tvalid = 2'b01;
      s_axis_tdata[63:0] = front;
      @(negedge clk);
      void'(q0.pop_front());
      apply_inputs();
    end
    s_axis_tdata[63:0] = q0[0];
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                           s_axis_tready, irq, err}, 64'd0);
    check("mid_rst_aw", {m_axi_awaddr, m_axi_awlen}, 64'd0);
    check("mid_rst_wr_ptr", wr_ptr, 64'd0);
    rst = 1'b0;
    s_axis_tvalid = 2'b00;
    m_axi_wready  = 1'b0;
    m_wr[0] = 0; m_wr[1] = 0; m_last = 1; m_err = 2'b00;
    run_until_idle(nb);
    check("post_rst_bursts", 64'(nb), 64'd1);

    // Randomised phases against the model.
    for (int r = 0; r < 15; r++) begin
      apply_phase(2'($urandom_range(1, 3)), $urandom_range(0, 40), $urandom_range(0, 40),
                  32'($urandom_range(0, 127) * 8), 32'($urandom_range(0, 255) * 8));
      err_mask = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_until_idle(nb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
